sequential_divider: RTL and testbench

Multi-cycle 32-bit signed integer divider for the ALU. It is the inverse of the combinational Booth multiplier. It accepts a dividend and a divisor on a start handshake and runs a non-restoring shift/subtract iteration, one quotient bit per clock. It returns a 64-bit result packed like the multiplier output: remainder in the HI word, quotient in the LO word. The ALU control FSM stalls on `busy` and latches the result into HI/LO on `done`.

---
 rtl/sequential_divider.sv | 141 ++++++++++++++
 tb/tb_sequential_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Multi-cycle 32-bit signed divider using non-restoring shift/subtract, one quotient bit per clock.
// Result is packed {remainder, quotient} to match the Booth multiplier's HI/LO layout.
module sequential_divider (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [63:0] divider_result
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [32:0] p_reg;
    logic [32:0] m_reg;
    logic [31:0] q_reg;
    logic [4:0]  count;
    logic        sign_q;
    logic        sign_r;
    logic        dz_flag;
    logic [31:0] quot_r;
    logic [31:0] rem_r;
    logic        busy_next;
    logic        done_next;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] p_shift;
    logic [32:0] p_iter;
    logic [32:0] p_fix;

    // |0x80000000| wraps to itself, which reads correctly as unsigned 2^31 in the 33-bit datapath.
    assign abs_a   = A[31] ? -A : A;
    assign abs_b   = B[31] ? -B : B;
    assign p_shift = {p_reg[31:0], q_reg[31]};
    assign p_iter  = p_reg[32] ? (p_shift + m_reg) : (p_shift - m_reg);
    assign p_fix   = p_reg[32] ? (p_reg + m_reg) : p_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (B == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered handshake outputs; busy stays up through the done cycle.
    always_comb begin
        busy_next = 1'b1;
        done_next = 1'b0;
        case (state)
            IDLE:    busy_next = start;
            DONE:    done_next = 1'b1;
            default: busy_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            p_reg          <= 33'd0;
            m_reg          <= 33'd0;
            q_reg          <= 32'd0;
            count          <= 5'd0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            dz_flag        <= 1'b0;
            quot_r         <= 32'd0;
            rem_r          <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            div_by_zero    <= 1'b0;
            divider_result <= 64'd0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        count       <= 5'd0;
                        if (B == 32'd0) begin
                            dz_flag <= 1'b1;
                            quot_r  <= 32'hFFFF_FFFF;
                            rem_r   <= A;
                        end else begin
                            dz_flag <= 1'b0;
                            q_reg   <= abs_a;
                            m_reg   <= {1'b0, abs_b};
                            p_reg   <= 33'd0;
                            sign_q  <= A[31] ^ B[31];
                            sign_r  <= A[31];
                        end
                    end
                end
                RUN: begin
                    p_reg <= p_iter;
                    q_reg <= {q_reg[30:0], ~p_iter[32]};
                    count <= count + 5'd1;
                end
                FIX: begin
                    p_reg  <= p_fix;
                    quot_r <= sign_q ? -q_reg : q_reg;
                    rem_r  <= sign_r ? -p_fix[31:0] : p_fix[31:0];
                end
                DONE: begin
                    divider_result <= {rem_r, quot_r};
                    div_by_zero    <= dz_flag;
                end
                default: begin
                    count <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed boundary cases plus a randomized sweep
// compared against a truncating-division model built from plain integer arithmetic.
module tb_sequential_divider;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] divider_result;

    int checks = 0;
    int errors = 0;

    sequential_divider dut (
        .clk            (clk),
        .clr            (clr),
        .start          (start),
        .A              (A),
        .B              (B),
        .busy           (busy),
        .done           (done),
        .div_by_zero    (div_by_zero),
        .divider_result (divider_result)
    );

    always #5 clk = ~clk;

    // Reference: signed truncating division in 64-bit arithmetic, so 0x80000000 / -1 cannot trap.
    function automatic logic [63:0] refDivide(input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        la = $signed(a);
        lb = $signed(b);
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Counts edges after the accepting edge until done is seen; busy is sampled after every edge.
    task automatic waitDone(output int latency, output int busy_cycles);
        latency     = 0;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && latency < 100) begin
            tick();
            latency++;
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expected);
        int lat;
        int bc;
        applyStimulus(a, b);
        waitDone(lat, bc);
        checkOutput({tag, " latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd34);
        checkOutput({tag, " busy_cycles"}, 64'(bc), (b == 32'd0) ? 64'd2 : 64'd35);
        checkOutput({tag, " result"}, divider_result, expected);
        checkOutput({tag, " div_by_zero"}, 64'(div_by_zero), 64'(b == 32'd0));
        tick();
        checkOutput({tag, " busy_done_after"}, 64'({busy, done}), 64'd0);
        checkOutput({tag, " result_held"}, divider_result, expected);
    endtask

    initial begin
        int          lat;
        int          bc;
        int          seen;
        int          gap;
        logic [31:0] ra;
        logic [31:0] rb;

        clr   = 1'b1;
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        #2;
        checkOutput("reset flags", 64'({busy, done, div_by_zero}), 64'd0);
        checkOutput("reset result", divider_result, 64'd0);
        tick();
        clr = 1'b0;
        tick();

        $display("[TB] directed operands");
        runOp("100/7",    32'd100,          32'd7,            64'h00000002_0000000E);
        runOp("-100/7",   -32'sd100,        32'd7,            64'hFFFFFFFE_FFFFFFF2);
        runOp("100/-7",   32'd100,          -32'sd7,          64'h00000002_FFFFFFF2);
        runOp("-100/-7",  -32'sd100,        -32'sd7,          64'hFFFFFFFE_0000000E);
        runOp("min/-1",   32'h8000_0000,    32'hFFFF_FFFF,    64'h00000000_80000000);
        runOp("min/1",    32'h8000_0000,    32'd1,            64'h00000000_80000000);
        runOp("0/5",      32'd0,            32'd5,            64'h0);
        runOp("5/max",    32'd5,            32'h7FFF_FFFF,    64'h00000005_00000000);
        runOp("7/0",      32'd7,            32'd0,            64'h00000007_FFFFFFFF);
        runOp("9/3",      32'd9,            32'd3,            64'h00000000_00000003);

        $display("[TB] start pulsed while busy");
        applyStimulus(32'd100, 32'd7);
        repeat (5) tick();
        start = 1'b1;
        A     = 32'd1;
        B     = 32'd1;
        tick();
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("ignored start latency", 64'(lat), 64'd28);
        checkOutput("ignored start result", divider_result, 64'h00000002_0000000E);
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen++;
        end
        checkOutput("no second done", 64'(seen), 64'd0);

        $display("[TB] start held high back to back");
        start = 1'b1;
        A     = 32'd20;
        B     = 32'd3;
        tick();
        A = 32'd30;
        B = 32'd4;
        waitDone(lat, bc);
        checkOutput("held first latency", 64'(lat), 64'd34);
        checkOutput("held first result", divider_result, 64'h00000002_00000006);
        tick();
        gap   = 1;
        start = 1'b0;
        checkOutput("held reaccept flags", 64'({busy, done}), 64'b10);
        while (done !== 1'b1 && gap < 100) begin
            tick();
            gap++;
        end
        checkOutput("held done spacing", 64'(gap), 64'd35);
        checkOutput("held second result", divider_result, 64'h00000002_00000007);
        tick();

        $display("[TB] clear during run");
        applyStimulus(32'd1234, 32'd5);
        repeat (10) tick();
        clr = 1'b1;
        #1;
        checkOutput("clear flags", 64'({busy, done, div_by_zero}), 64'd0);
        checkOutput("clear result", divider_result, 64'd0);
        tick();
        clr  = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen++;
        end
        checkOutput("no done after clear", 64'(seen), 64'd0);
        runOp("50/8", 32'd50, 32'd8, 64'h00000002_00000006);

        $display("[TB] random sweep");
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 20);
                2:       ra = -$urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 9);
                3:       rb = -$urandom_range(1, 9);
                4:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            runOp($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, refDivide(ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
